// File: rtl/pe_mac_signed.sv
// pe_mac_signed: signed multiply-accumulate processing element that forms one
// dot product per vector of VEC_LEN operand beats.
//
// Pipeline: stage 1 registers the full-precision product with first/last
// tags, stage 2 accumulates, and the final sum lands in the result register
// two edges after the edge that sampled the last beat.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   data_in_valid  operand beat strobe (upstream cannot be stalled)
//   last_count     beat index within the current vector
//   a_in, b_in     signed operands, DATA_W bits
//   result_ready   downstream takes the result on an edge where this is 1
//   result         signed dot-product result, ACC_W bits
//   result_valid   result holds a value not yet taken
//   busy           a vector is being accumulated or is draining
//   lost_result    sticky: an untaken result was overwritten
//   sat_flag       sticky: accumulator clipped (saturating build only)
//
// Build option: define PE_MAC_SAT_EN to clamp the accumulator to its signed
// range instead of wrapping; without it sat_flag is tied to 0.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no vector in progress, waiting for a first beat
// ST_ACCUM | beats of a vector are being sampled
// ST_DRAIN | last beat sampled, waiting for the result register load
module pe_mac_signed #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int VEC_LEN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_in_valid,
  input  logic [6:0]               last_count,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  input  logic                     result_ready,
  output logic signed [ACC_W-1:0]  result,
  output logic                     result_valid,
  output logic                     busy,
  output logic                     lost_result,
  output logic                     sat_flag
);

  localparam int PW = 2 * DATA_W;
  localparam logic [6:0] LAST_IDX = 7'(VEC_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                    first_pend_q, first_pend_d;
  logic signed [PW-1:0]    prod_q, prod_d;
  logic                    p_vld_q, p_vld_d;
  logic                    p_first_q, p_first_d;
  logic                    p_last_q, p_last_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    done_q, done_d;
  logic signed [ACC_W-1:0] result_q, result_d;
  logic                    result_valid_q, result_valid_d;
  logic                    lost_q, lost_d;

  logic                    beat_last;
  logic signed [ACC_W-1:0] prod_ext;
  logic                    load;

  assign beat_last = data_in_valid && (last_count == LAST_IDX);
  assign prod_ext  = ACC_W'(prod_q);
  assign load      = done_q;

  // Stage 1: product and tags. first_pend marks that the next sampled beat
  // opens a new vector (after reset or after a last beat).
  always_comb begin
    prod_d       = prod_q;
    p_vld_d      = 1'b0;
    p_first_d    = p_first_q;
    p_last_d     = p_last_q;
    first_pend_d = first_pend_q;
    if (data_in_valid) begin
      prod_d       = PW'(a_in) * PW'(b_in);
      p_vld_d      = 1'b1;
      p_first_d    = first_pend_q;
      p_last_d     = beat_last;
      first_pend_d = beat_last;
    end
  end

  // Stage 2: accumulate. A first-tagged product restarts the sum, so a new
  // vector can follow a last beat with no bubble.
`ifdef PE_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] sum_w;
  logic                  sat_q, sat_d;

  always_comb begin
    acc_d  = acc_q;
    sat_d  = sat_q;
    done_d = p_vld_q && p_last_q;
    sum_w  = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_ext);
    if (p_vld_q) begin
      if (p_first_q) begin
        acc_d = prod_ext;
      end else if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
        // Extra top bit disagrees with the ACC_W sign: clamp toward it.
        acc_d = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
        sat_d = 1'b1;
      end else begin
        acc_d = sum_w[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sat_q <= 1'b0;
    else      sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`else
  always_comb begin
    acc_d  = acc_q;
    done_d = p_vld_q && p_last_q;
    if (p_vld_q) begin
      if (p_first_q) acc_d = prod_ext;
      else           acc_d = acc_q + prod_ext;
    end
  end

  assign sat_flag = 1'b0;
`endif

  // Result register. acc_q already holds the finished sum when done_q is
  // set, even if stage 2 is starting the next vector on the same edge.
  always_comb begin
    result_d       = result_q;
    result_valid_d = result_valid_q && !result_ready;
    lost_d         = lost_q;
    if (load) begin
      result_d       = acc_q;
      result_valid_d = 1'b1;
      if (result_valid_q && !result_ready) lost_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (data_in_valid) begin
      if (beat_last) state_d = ST_DRAIN;
      else           state_d = ST_ACCUM;
    end else if (state_q == ST_DRAIN && load) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      first_pend_q   <= 1'b1;
      prod_q         <= '0;
      p_vld_q        <= 1'b0;
      p_first_q      <= 1'b0;
      p_last_q       <= 1'b0;
      acc_q          <= '0;
      done_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      first_pend_q   <= first_pend_d;
      prod_q         <= prod_d;
      p_vld_q        <= p_vld_d;
      p_first_q      <= p_first_d;
      p_last_q       <= p_last_d;
      acc_q          <= acc_d;
      done_q         <= done_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      lost_q         <= lost_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign lost_result  = lost_q;

endmodule

// File: tb/tb_pe_mac_signed.sv
// Directed bench for pe_mac_signed: default-width instance plus an ACC_W=16
// instance sharing the same stimulus for the overflow case.
module tb_pe_mac_signed;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              data_in_valid = 1'b0;
  logic [6:0]        last_count = '0;
  logic signed [7:0] a_in = '0;
  logic signed [7:0] b_in = '0;
  logic              result_ready = 1'b1;

  logic signed [23:0] res;
  logic               rv, bsy, lost, sat;
  logic signed [15:0] res16;
  logic               rv16, bsy16, lost16, sat16;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  pe_mac_signed #(.DATA_W(8), .ACC_W(24), .VEC_LEN(16)) dut (
    .clk(clk), .rst(rst), .data_in_valid(data_in_valid),
    .last_count(last_count), .a_in(a_in), .b_in(b_in),
    .result_ready(result_ready), .result(res), .result_valid(rv),
    .busy(bsy), .lost_result(lost), .sat_flag(sat)
  );

  pe_mac_signed #(.DATA_W(8), .ACC_W(16), .VEC_LEN(16)) dut16 (
    .clk(clk), .rst(rst), .data_in_valid(data_in_valid),
    .last_count(last_count), .a_in(a_in), .b_in(b_in),
    .result_ready(result_ready), .result(res16), .result_valid(rv16),
    .busy(bsy16), .lost_result(lost16), .sat_flag(sat16)
  );

  task automatic chk_val(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drives n beats; beat i goes out at a negedge and is sampled on the next
  // posedge. A 5-cycle valid-low gap is inserted before beat gap_at.
  // Returns with the last beat still driven.
  task automatic send_vec(input int a, input int b, input int n, input int gap_at);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < 5; g++) begin
          @(negedge clk);
          data_in_valid = 1'b0;
        end
      end
      @(negedge clk);
      data_in_valid = 1'b1;
      a_in          = 8'(a);
      b_in          = 8'(b);
      last_count    = 7'(i);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_in_valid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    chk_val("rst_result", res, 0);
    chk_val("rst_valid", 32'(rv), 0);
    chk_val("rst_busy", 32'(bsy), 0);
    chk_val("rst_lost", 32'(lost), 0);
    chk_val("rst_sat", 32'(sat), 0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // 3 * -2 over 16 beats, result_valid pulses two edges after beat 15
    result_ready = 1'b1;
    send_vec(3, -2, 16, -1);
    chk_val("v1_busy_accum", 32'(bsy), 1);
    idle(1);
    idle(1);
    chk_val("v1_valid_e1", 32'(rv), 0);
    chk_val("v1_busy_drain", 32'(bsy), 1);
    idle(1);
    chk_val("v1_valid_e2", 32'(rv), 1);
    chk_val("v1_result", res, -96);
    chk_val("v1_busy_idle", 32'(bsy), 0);
    idle(1);
    chk_val("v1_valid_e3", 32'(rv), 0);
    chk_val("v1_result_kept", res, -96);

    // most negative operands
    send_vec(-128, -128, 16, -1);
    chk_val("v2_busy_accum", 32'(bsy), 1);
    idle(2);
    chk_val("v2_busy_drain", 32'(bsy), 1);
    idle(1);
    chk_val("v2_result", res, 262144);
    chk_val("v2_valid", 32'(rv), 1);
    chk_val("v2_busy_idle", 32'(bsy), 0);

    // gap between beats 7 and 8, then a back-to-back vector
    idle(1);
    send_vec(3, -2, 16, 8);
    send_vec(1, 1, 16, -1);
    chk_val("gap_result", res, -96);
    chk_val("gap_lost", 32'(lost), 0);
    chk_val("b2b_busy", 32'(bsy), 1);
    idle(3);
    chk_val("b2b_result", res, 16);
    chk_val("b2b_valid", 32'(rv), 1);

    // result_ready held low across two completed vectors
    idle(1);
    result_ready = 1'b0;
    send_vec(3, -2, 16, -1);
    send_vec(1, 1, 16, -1);
    chk_val("hold_first", res, -96);
    chk_val("hold_first_valid", 32'(rv), 1);
    chk_val("hold_first_lost", 32'(lost), 0);
    idle(3);
    chk_val("hold_result", res, 16);
    chk_val("hold_valid", 32'(rv), 1);
    chk_val("hold_lost", 32'(lost), 1);
    result_ready = 1'b1;
    idle(1);
    chk_val("take_valid", 32'(rv), 0);
    chk_val("take_result", res, 16);
    chk_val("take_lost_sticky", 32'(lost), 1);

    // reset in the middle of a vector
    send_vec(3, -2, 10, -1);
    @(negedge clk);
    data_in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_val("mid_rst_result", res, 0);
    chk_val("mid_rst_valid", 32'(rv), 0);
    chk_val("mid_rst_busy", 32'(bsy), 0);
    chk_val("mid_rst_lost", 32'(lost), 0);
    chk_val("mid_rst_res16", res16, 0);
    idle(1);
    rst = 1'b1;
    send_vec(2, 5, 16, -1);
    idle(3);
    chk_val("post_rst_result", res, 160);
    chk_val("post_rst_valid", 32'(rv), 1);

    // take and load on the same edge
    idle(1);
    result_ready = 1'b0;
    send_vec(2, 5, 16, -1);
    idle(3);
    chk_val("sim_pre_result", res, 160);
    chk_val("sim_pre_valid", 32'(rv), 1);
    send_vec(1, 1, 16, -1);
    idle(1);
    idle(1);
    result_ready = 1'b1;
    idle(1);
    result_ready = 1'b0;
    chk_val("sim_result", res, 16);
    chk_val("sim_valid", 32'(rv), 1);
    chk_val("sim_lost", 32'(lost), 0);
    result_ready = 1'b1;
    idle(1);
    chk_val("sim_taken", 32'(rv), 0);

    // 127 * 127 over 16 beats: fits in 24 bits, overflows 16 bits
    send_vec(127, 127, 16, -1);
    idle(3);
    chk_val("big_result", res, 258064);
    chk_val("big_sat", 32'(sat), 0);
`ifdef PE_MAC_SAT_EN
    chk_val("acc16_result", res16, 32767);
    chk_val("acc16_sat", 32'(sat16), 1);
`else
    chk_val("acc16_result", res16, -4080);
    chk_val("acc16_sat", 32'(sat16), 0);
`endif

    idle(2);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
